// File: rtl/cbus_responder.sv
// cbus_responder: latency/burst memory responder over a 64-bit word array; define CBUS_RESPONDER_ERRCHK_EN for address-range error checking
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    logic        burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_responder
  import cbus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  req,
  output cbus_resp_t resp,
  output logic       busy,
  output logic       err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_END = 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] beat_q, beat_d, lat_q, lat_d, len_q, len_d;
  logic is_write_q, is_write_d, burst_q, burst_d;
  logic [63:0] addr_q, addr_d, off;
  logic [63:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic oob, beat, we, unused_ok;
  assign off  = ((addr_q - BASE_ADDR) >> 3) + 64'(burst_q ? beat_q : 4'd0);
  assign idx  = off[AW-1:0];
  assign beat = state_q == BEAT;
  assign we   = reset && beat && req.valid && is_write_q && !oob;
  assign busy = state_q != IDLE;
  assign resp = '{ready: beat, last: beat && beat_q == len_q,
                  data: !beat ? 64'd0 : oob ? 64'hDEAD_BEEF_DEAD_BEEF : is_write_q ? 64'd0 : mem[idx]};
`ifdef CBUS_RESPONDER_ERRCHK_EN
  logic err_q, err_d;
  assign oob   = (addr_q < BASE_ADDR) || (off >= 64'(DEPTH_WORDS));
  assign err_d = reset && (err_q || (beat && oob));
  // sticky range-error flag, cleared only by reset
  always_ff @(posedge clk) err_q <= err_d;
  assign err = err_q;
  assign unused_ok = ^req.size;
`else
  assign oob = 1'b0;
  assign err = 1'b0;
  assign unused_ok = ^{req.size, off[63:AW]};
`endif
  // next-state: accept in IDLE, count latency, step beats, abort when valid drops
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    len_d      = len_q;
    is_write_d = is_write_q;
    burst_d    = burst_q;
    addr_d     = addr_q;
    if (!reset) begin
      state_d = IDLE;
      beat_d  = 4'd0;
      lat_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: if (req.valid) begin
          state_d    = LATENCY == 0 ? BEAT : WAIT;
          beat_d     = 4'd0;
          lat_d      = 4'd0;
          len_d      = req.len;
          is_write_d = req.is_write;
          burst_d    = req.burst;
          addr_d     = req.addr;
        end
        WAIT: begin
          state_d = !req.valid ? IDLE : lat_q == LAT_END ? BEAT : WAIT;
          lat_d   = lat_q + 4'd1;
        end
        BEAT: begin
          state_d = !req.valid ? IDLE : beat_q == len_q ? DONE : BEAT;
          beat_d  = req.valid && beat_q != len_q ? beat_q + 4'd1 : beat_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // FSM and transaction registers
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    beat_q     <= beat_d;
    lat_q      <= lat_d;
    len_q      <= len_d;
    is_write_q <= is_write_d;
    burst_q    <= burst_d;
    addr_q     <= addr_d;
  end
  // byte-strobed write of the current beat's word
  always_ff @(posedge clk)
    if (we) for (int i = 0; i < 8; i++) if (req.strobe[i]) mem[idx][8*i +: 8] <= req.data[8*i +: 8];
endmodule

// File: doc/cbus_responder.md
CBUS_RESPONDER -- requirements
Module: cbus_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 64-bit words in the backing array (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 64'h8000_0000, byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, idle cycles between acceptance and first beat (0..15).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req  input  cbus_req_t  initiator request (valid, is_write, size, addr, strobe, data, len, burst).
REQ-007 SHALL have port resp  output  cbus_resp_t  response (ready, last, data).
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port err  output  1  sticky address-range error flag.

Function
REQ-010 SHALL implement states IDLE, WAIT, BEAT, DONE.
REQ-011 In IDLE, req.valid=1 SHALL latch is_write, addr, len, burst and go to WAIT (LATENCY>0) or BEAT (LATENCY=0) next cycle.
REQ-012 WAIT SHALL last exactly LATENCY cycles, then enter BEAT.
REQ-013 Beat count SHALL be len+1 (len=0 -> 1 beat, len=15 -> 16 beats), one beat per consecutive cycle in BEAT.
REQ-014 resp.ready SHALL be 1 in every BEAT cycle and 0 otherwise.
REQ-015 resp.last SHALL be 1 only in the BEAT cycle where beat counter equals latched len.
REQ-016 Word index SHALL be ((addr - BASE_ADDR) >> 3) + k for INCR and + 0 for FIXED, k = beat number from 0; addr[2:0] ignored.
REQ-017 Without the error-check macro, index SHALL wrap modulo DEPTH_WORDS.
REQ-018 Read beat: resp.data SHALL equal the array word at the beat index, combinationally, in the ready cycle; resp.data SHALL be 0 when ready=0.
REQ-019 Write beat: each byte i with req.strobe[i]=1 SHALL be written from req.data byte i at the edge ending the ready cycle; others unchanged; resp.data SHALL be 0.
REQ-020 req.size SHALL be ignored; strobe alone governs written bytes.
REQ-021 After the last beat the FSM SHALL enter DONE for exactly one cycle, ignoring req.valid, then IDLE.
REQ-022 req.valid=0 in WAIT or BEAT SHALL abort: no further beats, next state IDLE, already-written bytes retained.
REQ-023 Back-to-back transactions SHALL have minimum spacing last -> DONE -> IDLE-accept -> WAIT/BEAT.
REQ-024 req fields other than data/strobe SHALL be ignored after acceptance.

Reset
REQ-025 reset=0 at a clock edge SHALL force state IDLE, beat counter 0, latency counter 0, err 0; resp SHALL read all-zero and busy 0 the following cycle.
REQ-026 Reset mid-transaction SHALL abandon it with no further writes; array contents SHALL NOT be reset.

Configuration
REQ-027 Macro CBUS_RESPONDER_ERRCHK_EN: when defined, a beat whose (addr - BASE_ADDR) >> 3 plus offset is >= DEPTH_WORDS or whose addr < BASE_ADDR SHALL set err (sticky until reset), drop the write, return resp.data 64'hDEAD_BEEF_DEAD_BEEF, and keep normal ready/last timing.
REQ-028 When CBUS_RESPONDER_ERRCHK_EN is undefined, err SHALL be tied 0 and addresses SHALL wrap per REQ-017.

Verification
REQ-029 Single read: mem[0]=64'h1122_3344_5566_7788, read addr 8000_0000 len 0, LATENCY 2 -> ready+last on cycle 3 after accept, data 1122_3344_5566_7788, DONE then IDLE.
REQ-030 INCR write burst: len 3, addr 8000_0010, strobe FF, data 1,2,3,4 per beat -> mem[2..5]=1,2,3,4; last only on 4th ready.
REQ-031 Partial strobe: mem[1]=0, write strobe 8'h0F data 64'hAAAA_BBBB_CCCC_DDDD -> mem[1]=0000_0000_CCCC_DDDD.
REQ-032 FIXED read len 2 at mem[7]=5 -> three ready beats each data 5, last on third.
REQ-033 Abort: INCR write len 7, drop valid after 2nd beat -> mem[idx], mem[idx+1] written, rest untouched, busy 0 next cycle.
REQ-034 With CBUS_RESPONDER_ERRCHK_EN, DEPTH_WORDS 4096: read addr 8000_8000 -> data DEAD_BEEF_DEAD_BEEF, err=1 until reset=0; without macro same read returns mem[0].
